com_spram_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one com_spram_shell instance among REQ_N requesters.

---
 rtl/com_spram_arb.sv | 149 ++++++++++++++
 tb/tb_com_spram_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/com_spram_arb.sv
// Round-robin arbiter and sequencer that shares one single-port RAM shell
// among REQ_N requesters. It grants at most one access per cycle and returns
// read data to the requester that owns it. When INIT_EN is set, it zero-fills
// the whole RAM after reset, before any requester is served.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_INIT | zero-fill sweep, one write per cycle, requesters held off
//  ST_RUN  | round-robin arbitration, one RAM access per cycle
module com_spram_arb #(
  parameter int REQ_N   = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int STRB_W  = 1,
  parameter int INIT_EN = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_N-1:0]          req_vld,
  output logic [REQ_N-1:0]          req_rdy,
  input  logic [REQ_N-1:0]          req_wr,
  input  logic [REQ_N*STRB_W-1:0]   req_strb,
  input  logic [REQ_N*ADDR_W-1:0]   req_addr,
  input  logic [REQ_N*DATA_W-1:0]   req_wdata,
  output logic [REQ_N-1:0]          rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      init_done,
  output logic                      mem_ce_n,
  output logic [STRB_W-1:0]         mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int PTR_W = $clog2(REQ_N);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic                init_done_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [REQ_N-1:0]    rsp_vld_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                found;
  logic [PTR_W-1:0]    win;
  logic [PTR_W:0]      scan;
  logic [REQ_N-1:0]    gnt;
  logic                win_wr;
  logic [STRB_W-1:0]   win_strb;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                init_last;

  assign init_last = (init_cnt_q == ADDR_W'(DEPTH - 1));

  // Pick the first valid requester at or after rr_ptr, wrapping modulo REQ_N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    gnt   = '0;
    if (!rst && state_q == ST_RUN) begin
      for (int k = 0; k < REQ_N; k++) begin
        scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (scan >= (PTR_W+1)'(REQ_N)) scan = scan - (PTR_W+1)'(REQ_N);
        if (!found && req_vld[scan[PTR_W-1:0]]) begin
          found = 1'b1;
          win   = scan[PTR_W-1:0];
        end
      end
      if (found) gnt[win] = 1'b1;
    end
  end

  assign win_wr    = req_wr[win];
  assign win_strb  = req_strb[int'(win)*STRB_W +: STRB_W];
  assign win_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];

  // Next state and RAM port drive; an idle port keeps addr/data steady.
  always_comb begin
    state_d     = state_q;
    mem_ce_n    = 1'b1;
    mem_we      = '0;
    mem_addr    = addr_q;
    mem_wr_data = wdata_q;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          mem_ce_n    = 1'b0;
          mem_we      = '1;
          mem_addr    = init_cnt_q;
          mem_wr_data = '0;
          if (init_last) state_d = ST_RUN;
        end
        default: begin
          if (found) begin
            mem_addr    = win_addr;
            mem_wr_data = win_wdata;
            if (win_wr) begin
              // A write with no strobe lanes is consumed, never issued.
              mem_we   = win_strb;
              mem_ce_n = ~|win_strb;
            end else begin
              mem_ce_n = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State, pointer, clear counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= (INIT_EN == 0);
      rr_ptr_q    <= '0;
      rsp_vld_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= mem_addr;
      wdata_q   <= mem_wr_data;
      rsp_vld_q <= (found && !win_wr) ? gnt : '0;
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + ADDR_W'(1);
        if (init_last) init_done_q <= 1'b1;
      end
      if (found) begin
        rr_ptr_q <= (win == PTR_W'(REQ_N - 1)) ? '0 : win + PTR_W'(1);
      end
    end
  end

  assign req_rdy   = gnt;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_data  = mem_rd_data;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_com_spram_arb.sv
// Bench for com_spram_arb: 4 requesters, 32-bit data, 2 strobe lanes, 64 words.
module tb_com_spram_arb;
  localparam int REQ_N  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int STRB_W = 2;
  localparam int ADDR_W = 6;
  localparam int LANE   = DATA_W / STRB_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [REQ_N-1:0]         req_vld = '0;
  logic [REQ_N-1:0]         req_rdy;
  logic [REQ_N-1:0]         req_wr = '0;
  logic [REQ_N*STRB_W-1:0]  req_strb = '0;
  logic [REQ_N*ADDR_W-1:0]  req_addr = '0;
  logic [REQ_N*DATA_W-1:0]  req_wdata = '0;
  logic [REQ_N-1:0]         rsp_vld;
  logic [DATA_W-1:0]        rsp_data;
  logic                     init_done;
  logic                     mem_ce_n;
  logic [STRB_W-1:0]        mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wr_data;
  logic [DATA_W-1:0]        mem_rd_data = '0;

  com_spram_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W), .DEPTH(DEPTH),
                  .STRB_W(STRB_W), .INIT_EN(1)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_wr(req_wr), .req_strb(req_strb), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .init_done(init_done), .mem_ce_n(mem_ce_n), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Shell model: synchronous RAM, one-cycle read, per-lane write enables.
  logic [DATA_W-1:0] shell_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) shell_mem[i] = 32'hDEAD_BEEF ^ i;
  always @(posedge clk) begin
    if (!mem_ce_n) begin
      if (mem_we == '0) mem_rd_data <= shell_mem[mem_addr];
      else for (int l = 0; l < STRB_W; l++)
        if (mem_we[l]) shell_mem[mem_addr][l*LANE +: LANE] <= mem_wr_data[l*LANE +: LANE];
    end
  end

  int errors = 0;
  int checks = 0;

  typedef struct { int id; logic [DATA_W-1:0] data; } rsp_t;
  rsp_t sb_q[$];

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                m_ptr;
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_last_wd;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    logic [REQ_N-1:0] oh;
    if (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      oh = REQ_N'(1) << e.id;
      chk("rsp_vld", 64'(rsp_vld), 64'(oh));
      chk("rsp_data", 64'(rsp_data), 64'(e.data));
    end else begin
      chk("rsp_idle", 64'(rsp_vld), 64'(0));
    end
  endtask

  // Called at a negedge: check last cycle's response, drive, check port, model, advance.
  task automatic cycle(input logic [REQ_N-1:0] vld, input logic [REQ_N-1:0] wr,
                       input logic [REQ_N*STRB_W-1:0] strb,
                       input logic [REQ_N*ADDR_W-1:0] addr,
                       input logic [REQ_N*DATA_W-1:0] wdata);
    int win;
    logic [REQ_N-1:0] e_rdy;
    logic e_ce;
    logic [STRB_W-1:0] e_we, s;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    check_rsp();
    req_vld = vld; req_wr = wr; req_strb = strb; req_addr = addr; req_wdata = wdata;
    #1;
    win = -1;
    for (int k = 0; k < REQ_N; k++)
      if (win < 0 && vld[(m_ptr + k) % REQ_N]) win = (m_ptr + k) % REQ_N;
    e_rdy = '0; e_ce = 1'b1; e_we = '0; a = m_last_addr; d = m_last_wd;
    if (win >= 0) begin
      e_rdy[win] = 1'b1;
      a = addr[win*ADDR_W +: ADDR_W];
      d = wdata[win*DATA_W +: DATA_W];
      s = strb[win*STRB_W +: STRB_W];
      if (wr[win]) begin e_we = s; e_ce = (s == '0); end
      else e_ce = 1'b0;
    end
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("mem_ce_n", 64'(mem_ce_n), 64'(e_ce));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(a));
    chk("mem_wr_data", 64'(mem_wr_data), 64'(d));
    if (win >= 0) begin
      m_ptr = (win + 1) % REQ_N;
      if (wr[win]) begin
        for (int l = 0; l < STRB_W; l++)
          if (s[l]) ref_mem[a][l*LANE +: LANE] = d[l*LANE +: LANE];
      end else begin
        sb_q.push_back('{id: win, data: ref_mem[a]});
      end
    end
    m_last_addr = a; m_last_wd = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle('0, '0, '0, '0, '0);
  endtask

  // Follow the clear sweep with every requester asking; stops early if n < DEPTH.
  task automatic run_init(input int n);
    req_vld = '1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("init_ce_n", 64'(mem_ce_n), 64'(0));
      chk("init_we", 64'(mem_we), 64'(2'b11));
      chk("init_addr", 64'(mem_addr), 64'(k));
      chk("init_wd", 64'(mem_wr_data), 64'(0));
      chk("init_rdy", 64'(req_rdy), 64'(0));
      chk("init_done_lo", 64'(init_done), 64'(0));
      chk("init_rsp", 64'(rsp_vld), 64'(0));
      @(negedge clk);
    end
    if (n == DEPTH) chk("init_done_hi", 64'(init_done), 64'(1));
    req_vld = '0;
  endtask

  initial begin
    logic [REQ_N*ADDR_W-1:0] aa;
    logic [REQ_N*DATA_W-1:0] dd;
    repeat (3) @(negedge clk);
    req_vld = '1;
    #1;
    chk("rst_ce_n", 64'(mem_ce_n), 64'(1));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_rdy", 64'(req_rdy), 64'(0));
    chk("rst_rsp", 64'(rsp_vld), 64'(0));
    chk("rst_done", 64'(init_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    // T5: abort the clear at cycle 20, then a full clear from address 0
    run_init(20);
    rst = 1'b1;
    #1;
    chk("t5_rst_ce_n", 64'(mem_ce_n), 64'(1));
    chk("t5_rst_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    // T1: full clear sweep
    run_init(DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_ptr = 0; m_last_addr = ADDR_W'(DEPTH - 1); m_last_wd = '0;

    // T2: all four write continuously -> 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < REQ_N; r++) aa[r*ADDR_W +: ADDR_W] = ADDR_W'(8 + r*8 + c);
      dd = {$urandom, $urandom, $urandom, $urandom};
      cycle(4'hF, 4'hF, 8'hFF, aa, dd);
    end
    // back-to-back reads from all four
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < REQ_N; r++) aa[r*ADDR_W +: ADDR_W] = ADDR_W'(8 + r*8 + c);
      cycle(4'hF, 4'h0, 8'h00, aa, '0);
    end

    // T3: req0 writes addr 5, req2 reads it next cycle
    cycle(4'b0001, 4'b0001, 8'h03, 24'(5), 128'hA5A5A5A5);
    cycle(4'b0100, 4'b0000, 8'h00, 24'(5) << (2*ADDR_W), '0);
    idle();

    // T4: strobed partial write, then a zero-strobe write that must not reach the RAM
    cycle(4'b0010, 4'b0010, 8'h03 << 2, 24'(3) << ADDR_W, 128'hFFFF_FFFF << 32);
    cycle(4'b0010, 4'b0010, 8'h01 << 2, 24'(3) << ADDR_W, '0);
    cycle(4'b0010, 4'b0010, 8'h00, 24'(3) << ADDR_W, 128'h1234_5678 << 32);
    cycle(4'b0010, 4'b0000, 8'h00, 24'(3) << ADDR_W, '0);
    idle();

    // T6: req3 alone, then req1 joins
    for (int c = 0; c < 3; c++) cycle(4'b1000, 4'b0000, 8'h00, 24'(9) << (3*ADDR_W), '0);
    for (int c = 0; c < 3; c++)
      cycle(4'b1010, 4'b0000, 8'h00, (24'(9) << (3*ADDR_W)) | (24'(3) << ADDR_W), '0);
    idle();

    // reset mid-RUN drops a pending response
    cycle(4'b0001, 4'b0000, 8'h00, 24'(5), '0);
    rst = 1'b1;
    #1;
    chk("rst_drop_rsp", 64'(rsp_vld), 64'(0));
    sb_q.delete();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
